// File: rtl/and_r1_2ph_join.sv
// ---------------------------------------------------------------------------
// and_r1_2ph_join
//
// Clocked two-phase (transition-signalling) join. Two 2-phase producers
// (r1/a1, r2/a2) feed one 2-phase consumer (r/a). One output event is issued
// per pair of input events, and both inputs are acknowledged together once the
// consumer has acknowledged the output event.
//
// Ports
//   clk       in   single clock, all state updates on posedge
//   rst_async in   asynchronous active-high reset
//   r1        in   channel-1 request (each transition is one event)
//   a1        out  channel-1 acknowledge
//   r2        in   channel-2 request
//   a2        out  channel-2 acknowledge
//   r         out  output-channel request
//   a         in   output-channel acknowledge from consumer
//
// Parameters
//   SYNC_STAGES  synchronizer depth on r1, r2 and a (>= 2); only takes effect
//                when the build macro AND_R1_SYNC_EN is defined.
//
// Build option
//   AND_R1_SYNC_EN  defined: r1, r2 and a pass through SYNC_STAGES-flop
//                   synchronizers, adding SYNC_STAGES clk to each latency.
//                   undefined: inputs are used directly and must be
//                   synchronous to clk.
//
// State | Meaning
//   WAIT_IN  | waiting for an event pending on both r1 and r2
//   WAIT_OUT | output event issued, waiting for consumer ack (a == r)
// ---------------------------------------------------------------------------
module and_r1_2ph_join #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_async,
    input  logic r1,
    output logic a1,
    input  logic r2,
    output logic a2,
    output logic r,
    input  logic a
);

    localparam logic [0:0] WAIT_IN  = 1'b0;
    localparam logic [0:0] WAIT_OUT = 1'b1;

    // Elaboration-time legality check on the synchronizer depth.
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("and_r1_2ph_join: SYNC_STAGES must be >= 2");
    end

    logic r1_s;
    logic r2_s;
    logic a_s;

`ifdef AND_R1_SYNC_EN
    logic [SYNC_STAGES-1:0] r1_sync_q, r1_sync_d;
    logic [SYNC_STAGES-1:0] r2_sync_q, r2_sync_d;
    logic [SYNC_STAGES-1:0] a_sync_q,  a_sync_d;

    // Shift toward the MSB; the MSB is the fully synchronized copy.
    always_comb begin
        r1_sync_d = {r1_sync_q[SYNC_STAGES-2:0], r1};
        r2_sync_d = {r2_sync_q[SYNC_STAGES-2:0], r2};
        a_sync_d  = {a_sync_q[SYNC_STAGES-2:0],  a};
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r1_sync_q <= '0;
            r2_sync_q <= '0;
            a_sync_q  <= '0;
        end else begin
            r1_sync_q <= r1_sync_d;
            r2_sync_q <= r2_sync_d;
            a_sync_q  <= a_sync_d;
        end
    end

    assign r1_s = r1_sync_q[SYNC_STAGES-1];
    assign r2_s = r2_sync_q[SYNC_STAGES-1];
    assign a_s  = a_sync_q[SYNC_STAGES-1];
`else
    assign r1_s = r1;
    assign r2_s = r2;
    assign a_s  = a;
`endif

    logic [0:0] state_q, state_d;
    logic       r_q,  r_d;
    logic       a1_q, a1_d;
    logic       a2_q, a2_d;

    logic p1;
    logic p2;
    logic out_busy;

    assign p1       = r1_s ^ a1_q;
    assign p2       = r2_s ^ a2_q;
    assign out_busy = r_q ^ a_s;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        case (state_q)
            WAIT_IN: begin
                // A single pending channel just waits for its partner.
                // Simultaneous r1/r2 transitions land here together and
                // produce exactly one output event.
                if (p1 && p2 && !out_busy) begin
                    r_d     = ~r_q;
                    state_d = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                // Both producers are released in the same cycle so the
                // pair stays in lock-step.
                if (!out_busy) begin
                    a1_d    = ~a1_q;
                    a2_d    = ~a2_q;
                    state_d = WAIT_IN;
                end
            end
            default: begin
                state_d = WAIT_IN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q <= WAIT_IN;
            r_q     <= 1'b0;
            a1_q    <= 1'b0;
            a2_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
        end
    end

    assign r  = r_q;
    assign a1 = a1_q;
    assign a2 = a2_q;

endmodule

// File: tb/tb_and_r1_2ph_join.sv
module tb_and_r1_2ph_join;

    logic clk;
    logic rst_async;
    logic r1, r2, a;
    logic a1, a2, r;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic r;
        logic a1;
        logic a2;
    } exp_t;

    exp_t sb_q[$];
    logic stress_q[$];

    // stress bookkeeping
    int   ev1, ev2, joins;
    int   r_edges, a1_edges, a2_edges;
    int   a_dly;
    logic r_prev, a1_prev, a2_prev;
    logic gen_en;
    logic quiet;

    and_r1_2ph_join #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .r1        (r1),
        .a1        (a1),
        .r2        (r2),
        .a2        (a2),
        .r         (r),
        .a         (a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic er, input logic ea1, input logic ea2);
        exp_t e;
        e.r  = er;
        e.a1 = ea1;
        e.a2 = ea2;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, logic'(sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_r"},  r,  e.r);
            chk({tag, "_a1"}, a1, e.a1);
            chk({tag, "_a2"}, a2, e.a2);
        end
    endtask

    // Per-cycle output monitor used by the stress phase.
    task automatic monitor_cycle();
        logic er;
        if (r !== r_prev) begin
            r_edges++;
            if (r === 1'b1) chk("stress_rise_needs_r1_r2", r1 & r2, 1'b1);
            chk("stress_sb_nonempty", logic'(stress_q.size() > 0), 1'b1);
            if (stress_q.size() > 0) begin
                er = stress_q.pop_front();
                chk("stress_r_level", r, er);
            end
        end
        if (a1 !== a1_prev) a1_edges++;
        if (a2 !== a2_prev) a2_edges++;
        r_prev  = r;
        a1_prev = a1;
        a2_prev = a2;
    endtask

    task automatic drive_cycle();
        if (gen_en) begin
            if (r1 === a1 && $urandom_range(0, 3) == 0) begin
                r1 = ~r1;
                ev1++;
            end
            if (r2 === a2 && $urandom_range(0, 3) == 0) begin
                r2 = ~r2;
                ev2++;
            end
        end
        if (ev1 > joins && ev2 > joins) begin
            joins++;
            stress_q.push_back(logic'(joins % 2));
        end
        // echo slave: a follows r after a random delay
        if (r !== a) begin
            if (a_dly == 0) a = r;
            else a_dly--;
        end else begin
            a_dly = $urandom_range(0, 4);
        end
    endtask

    initial begin
        rst_async = 1'b1;
        r1 = 1'b0;
        r2 = 1'b0;
        a  = 1'b0;

        // reset
        #6;
        chk("reset_r",  r,  1'b0);
        chk("reset_a1", a1, 1'b0);
        chk("reset_a2", a2, 1'b0);
        step();
        rst_async = 1'b0;
        repeat (3) step();
        chk("post_reset_r",  r,  1'b0);
        chk("post_reset_a1", a1, 1'b0);
        chk("post_reset_a2", a2, 1'b0);

        // single channel pending: nothing happens
        r1 = 1'b1;
        repeat (10) begin
            step();
            chk("single_r", r, 1'b0);
        end
        chk("single_a1", a1, 1'b0);
        chk("single_a2", a2, 1'b0);

        // full join, then consumer ack
        r2 = 1'b1;
        sb_push(1'b1, 1'b0, 1'b0);
        step();
        sb_check("join_req");
        a = 1'b1;
        sb_push(1'b1, 1'b1, 1'b1);
        step();
        sb_check("join_ack");
        repeat (3) step();
        sb_push(1'b1, 1'b1, 1'b1);
        sb_check("join_idle");

        // second phase: falling transitions
        r1 = 1'b0;
        repeat (3) step();
        sb_push(1'b1, 1'b1, 1'b1);
        sb_check("ph2_single");
        r2 = 1'b0;
        sb_push(1'b0, 1'b1, 1'b1);
        step();
        sb_check("ph2_req");
        a = 1'b0;
        sb_push(1'b0, 1'b0, 1'b0);
        step();
        sb_check("ph2_ack");

        // simultaneous transitions count as one join
        r1 = 1'b1;
        r2 = 1'b1;
        sb_push(1'b1, 1'b0, 1'b0);
        step();
        sb_check("simul_req");
        repeat (3) step();
        sb_push(1'b1, 1'b0, 1'b0);
        sb_check("simul_one_event");
        a = 1'b1;
        sb_push(1'b1, 1'b1, 1'b1);
        step();
        sb_check("simul_ack");

        // reversed arrival order (r2 first)
        r2 = 1'b0;
        repeat (2) step();
        sb_push(1'b1, 1'b1, 1'b1);
        sb_check("rev_single");
        r1 = 1'b0;
        sb_push(1'b0, 1'b1, 1'b1);
        step();
        sb_check("rev_req");
        a = 1'b0;
        sb_push(1'b0, 1'b0, 1'b0);
        step();
        sb_check("rev_ack");

        // reset mid-handshake: outputs drop without a clock edge
        r1 = 1'b1;
        r2 = 1'b1;
        sb_push(1'b1, 1'b0, 1'b0);
        step();
        sb_check("midrst_req");
        a = 1'b1;
        step();
        #1;
        rst_async = 1'b1;
        r1 = 1'b0;
        r2 = 1'b0;
        a  = 1'b0;
        #1;
        chk("midrst_r",  r,  1'b0);
        chk("midrst_a1", a1, 1'b0);
        chk("midrst_a2", a2, 1'b0);
        step();
        rst_async = 1'b0;
        repeat (2) step();
        chk("midrst_idle_r", r, 1'b0);

        // random stress: 20000 cycles = 200us
        ev1 = 0; ev2 = 0; joins = 0;
        r_edges = 0; a1_edges = 0; a2_edges = 0;
        a_dly = 0;
        r_prev = r; a1_prev = a1; a2_prev = a2;
        gen_en = 1'b1;
        repeat (20000) begin
            step();
            monitor_cycle();
            drive_cycle();
        end

        // drain: generators stop, echo slave keeps going
        gen_en = 1'b0;
        quiet  = 1'b0;
        for (int i = 0; i < 300 && !quiet; i++) begin
            step();
            monitor_cycle();
            drive_cycle();
            quiet = (r === a) && (r1 === a1) && (r2 === a2) && (stress_q.size() == 0);
        end
        chk("stress_no_deadlock", quiet, 1'b1);
        chk("stress_events_seen", logic'(ev1 > 100), 1'b1);
        chk("stress_ev1_eq_ev2", logic'(ev1 == ev2), 1'b1);
        chk("stress_r_edges", logic'(r_edges == ev1), 1'b1);
        chk("stress_a1_edges", logic'(a1_edges == ev1), 1'b1);
        chk("stress_a2_edges", logic'(a2_edges == ev2), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
